hdlc_rx_buff_p: RTL

HDLC_RX_BUFF_P -- requirements
Module: hdlc_rx_buff_p

---
 rtl/hdlc_rx_buff_p.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/hdlc_rx_buff_p.sv
// hdlc_rx_buff_p: HDLC receive frame buffer. The write side stores received
// words into a frame bank and hands complete, FCS-clean frames to the read side,
// which presents one frame at a time to the CPU.
// Optional macro HDLC_RX_BUFF_PINGPONG_EN: two banks operate as an in-order
// queue. When the macro is undefined (the default), a single bank is built.
module hdlc_rx_buff_p #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned FCS_BYTES = 2,
    parameter int unsigned SIZE_W    = $clog2(DEPTH + 1)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Rx_WrBuff,
    input  logic [DATA_W-1:0] Rx_Data,
    input  logic              Rx_EoF,
    input  logic              Rx_FCSerr,
    input  logic              Rx_FrameError,
    input  logic              Rx_AbortSignal,
    input  logic              Rx_Drop,
    input  logic              Rx_RdBuff,
    output logic [DATA_W-1:0] Rx_DataBuffOut,
    output logic              Rx_Ready,
    output logic [SIZE_W-1:0] Rx_FrameSize,
    output logic              Rx_Overflow
);

`ifdef HDLC_RX_BUFF_PINGPONG_EN
    localparam int unsigned NB       = 2;
    localparam logic        BANK_TGL = 1'b1;
`else
    localparam int unsigned NB       = 1;
    localparam logic        BANK_TGL = 1'b0;
`endif
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_FILL  = 2'd1;
    localparam logic [1:0] W_OVF   = 2'd2;
    localparam logic [1:0] W_WAIT  = 2'd3;
    localparam logic       R_EMPTY = 1'b0;
    localparam logic       R_READY = 1'b1;

    logic [DATA_W-1:0] r_mem [NB][DEPTH];

    logic [1:0]        r_wstate;
    logic [SIZE_W-1:0] r_wcnt;
    logic              r_wbank;
    logic [NB-1:0]     r_full;
    logic [SIZE_W-1:0] r_size [NB];
    logic [NB-1:0]     r_ovf;

    logic              r_rstate;
    logic              r_rbank;
    logic [SIZE_W-1:0] r_rdptr;
    logic [DATA_W-1:0] r_dout;
    logic [SIZE_W-1:0] r_frame_size;
    logic              r_overflow;

    logic [1:0]        w_wstate_nxt;
    logic [SIZE_W-1:0] w_wcnt_nxt;
    logic [SIZE_W-1:0] w_eff_cnt;
    logic              w_wr_en;
    logic              w_ovf_end;
    logic              w_deliver;
    logic              w_rstate_nxt;
    logic              w_rd_en;
    logic              w_release;

    // Write FSM next state: word acceptance, overflow and end-of-frame decision
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wr_en      = 1'b0;
        w_ovf_end    = 1'b0;
        w_deliver    = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (Rx_WrBuff) begin
                    if (r_full[r_wbank]) begin
                        w_wstate_nxt = W_WAIT;
                    end else begin
                        w_wr_en      = 1'b1;
                        w_wstate_nxt = W_FILL;
                    end
                end
            end
            W_FILL: begin
                if (Rx_WrBuff) begin
                    if (r_wcnt == SIZE_W'(DEPTH)) begin
                        w_wstate_nxt = W_OVF;
                        w_ovf_end    = 1'b1;
                    end else begin
                        w_wr_en = 1'b1;
                    end
                end
            end
            W_OVF:   w_ovf_end = 1'b1;
            default: ;
        endcase
        // A word written alongside EoF counts toward the frame size
        w_eff_cnt  = w_wr_en ? (r_wcnt + SIZE_W'(1)) : r_wcnt;
        w_wcnt_nxt = w_eff_cnt;
        if (Rx_FrameError || Rx_AbortSignal) begin
            w_wstate_nxt = W_IDLE;
            w_wr_en      = 1'b0;
            w_wcnt_nxt   = '0;
        end else if (Rx_EoF) begin
            w_wstate_nxt = W_IDLE;
            w_wcnt_nxt   = '0;
            w_deliver    = (r_wstate != W_WAIT) && !Rx_FCSerr &&
                           (w_eff_cnt > SIZE_W'(FCS_BYTES));
        end
    end

    // Write FSM state, fill count and per-bank frame descriptors
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_wstate <= W_IDLE;
            r_wcnt   <= '0;
            r_wbank  <= 1'b0;
            r_ovf    <= '0;
            for (int i = 0; i < NB; i++) r_size[i] <= '0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_wcnt   <= w_wcnt_nxt;
            if (w_deliver) begin
                r_size[r_wbank] <= w_eff_cnt - SIZE_W'(FCS_BYTES);
                r_ovf[r_wbank]  <= w_ovf_end;
                r_wbank         <= r_wbank ^ BANK_TGL;
            end
        end
    end

    // Frame RAM write port, no reset needed
    always_ff @(posedge Clk) begin
        if (w_wr_en) r_mem[r_wbank][AW'(r_wcnt)] <= Rx_Data;
    end

    // Bank ownership: set by a delivered frame, cleared on read-side release
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_full <= '0;
        end else begin
            if (w_deliver) r_full[r_wbank] <= 1'b1;
            if (w_release) r_full[r_rbank] <= 1'b0;
        end
    end

    // Read FSM next state: present, read out and release the oldest bank
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rd_en      = 1'b0;
        w_release    = 1'b0;
        case (r_rstate)
            R_EMPTY: begin
                if (r_full[r_rbank]) w_rstate_nxt = R_READY;
            end
            default: begin
                if (Rx_Drop) begin
                    w_release    = 1'b1;
                    w_rstate_nxt = R_EMPTY;
                end else if (Rx_RdBuff) begin
                    w_rd_en = 1'b1;
                    if ((r_rdptr + SIZE_W'(1)) == r_frame_size) begin
                        w_release    = 1'b1;
                        w_rstate_nxt = R_EMPTY;
                    end
                end
            end
        endcase
    end

    // Read FSM state, read pointer and registered outputs
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_rstate     <= R_EMPTY;
            r_rbank      <= 1'b0;
            r_rdptr      <= '0;
            r_dout       <= '0;
            r_frame_size <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (w_rd_en) begin
                r_dout  <= r_mem[r_rbank][AW'(r_rdptr)];
                r_rdptr <= r_rdptr + SIZE_W'(1);
            end
            if (w_release) begin
                r_rdptr      <= '0;
                r_rbank      <= r_rbank ^ BANK_TGL;
                r_frame_size <= '0;
                r_overflow   <= 1'b0;
            end else if ((r_rstate == R_EMPTY) && r_full[r_rbank]) begin
                r_frame_size <= r_size[r_rbank];
                r_overflow   <= r_ovf[r_rbank];
            end
        end
    end

    assign Rx_DataBuffOut = r_dout;
    assign Rx_Ready       = (r_rstate == R_READY);
    assign Rx_FrameSize   = r_frame_size;
    assign Rx_Overflow    = r_overflow;

endmodule
